cellrv32_cpu_cp_arbiter: RTL and testbench

Dispatch and collection stage directly upstream and downstream of the CPU base-ISA co-processors (shifter, mul/div, bitmanip, ...).
It accepts one operation request from the execute control path and pulses the selected co-processor's start. It then waits for that unit's valid, samples the unit's gated result one cycle later, and returns a registered result plus a done pulse to the ALU result path.
It also aborts the operation on a trap, and flags a timeout when a co-processor never responds.

---
 rtl/cellrv32_cpu_cp_arbiter.sv | 156 +++++++++++++++
 tb/tb_cellrv32_cpu_cp_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_cpu_cp_arbiter.sv
// Co-processor dispatch/collect stage for the base-ISA co-processors.
// Accepts a single request from execute, pulses the selected unit's start,
// waits for its valid, samples its result one cycle later and returns it
// with a done pulse. Traps abort the operation; silent units time out.
//
// Handshake: req_i is a one-cycle pulse taken only while busy_o=0. Every
// accepted or rejected request produces exactly one done_o pulse unless a
// trap aborts it. A request while busy_o=1 is dropped silently. A unit's
// cp_valid_i means "result on cp_res_i in the next cycle".
module cellrv32_cpu_cp_arbiter #(
    parameter int XLEN       = 32,
    parameter int NUM_CP     = 4,
    parameter int TMO_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   req_i,
    input  logic [2:0]             sel_i,
    input  logic                   trap_i,
    output logic [NUM_CP-1:0]      cp_start_o,
    input  logic [NUM_CP-1:0]      cp_valid_i,
    input  logic [NUM_CP*XLEN-1:0] cp_res_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [XLEN-1:0]        res_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    localparam logic [3:0] NUM_CP_W = 4'(NUM_CP);
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    // state_q doubles as the debug view of the FSM
    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NUM_CP-1:0] start_d;
    logic              done_d, err_d;
    logic [XLEN-1:0]   res_d;

    logic              sel_ok;
    logic [NUM_CP-1:0] sel_onehot;
    logic              valid_sel;
    logic [XLEN-1:0]   res_sel;

    // Decode the incoming index and mux the latched unit's valid/result
    always_comb begin
        sel_ok     = ({1'b0, sel_i} < NUM_CP_W);
        sel_onehot = '0;
        valid_sel  = 1'b0;
        res_sel    = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            sel_onehot[k] = (sel_i == 3'(k));
            if (sel_q == 3'(k)) begin
                valid_sel = cp_valid_i[k];
                res_sel   = cp_res_i[k*XLEN +: XLEN];
            end
        end
    end

    // Next-state and next-output logic; trap has priority over everything
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        start_d = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        res_d   = res_o;
        case (state_q)
            S_IDLE: begin
                if (req_i && !trap_i) begin
                    if (sel_ok) begin
                        sel_d   = sel_i;
                        start_d = sel_onehot;
                        state_d = S_START;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        res_d  = '0;
                    end
                end
            end
            S_START: begin
                cnt_d = '0;
                if (trap_i) begin
                    state_d = S_IDLE;
                end else if (valid_sel) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (trap_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (valid_sel) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    // Unit never answered: report an error with a zero result
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    res_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (!trap_i) begin
                    res_d  = res_sel;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously on reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            cp_start_o <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            res_o      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            cp_start_o <= start_d;
            done_o     <= done_d;
            err_o      <= err_d;
            res_o      <= res_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_cellrv32_cpu_cp_arbiter.sv
// Self-checking bench for cellrv32_cpu_cp_arbiter with behavioural
// co-processor models and a done/start scoreboard.
module tb_cellrv32_cpu_cp_arbiter;

    localparam int XLEN   = 32;
    localparam int NUM_CP = 4;
    localparam int TMO    = 64;

    // clock / reset
    logic clk_i = 1'b0;
    logic rstn_i;
    always #5 clk_i = ~clk_i;

    logic                   req_i;
    logic [2:0]             sel_i;
    logic                   trap_i;
    logic [NUM_CP-1:0]      cp_start_o;
    logic [NUM_CP-1:0]      cp_valid_i;
    logic [NUM_CP*XLEN-1:0] cp_res_i;
    logic                   busy_o;
    logic                   done_o;
    logic [XLEN-1:0]        res_o;
    logic                   err_o;

    cellrv32_cpu_cp_arbiter #(
        .XLEN(XLEN), .NUM_CP(NUM_CP), .TMO_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .sel_i(sel_i),
        .trap_i(trap_i), .cp_start_o(cp_start_o), .cp_valid_i(cp_valid_i),
        .cp_res_i(cp_res_i), .busy_o(busy_o), .done_o(done_o),
        .res_o(res_o), .err_o(err_o)
    );

    // scoreboard: done entries {cycle[30:0], err, res}, start entries {cycle, mask}
    logic [63:0] exp_q[$];
    logic [35:0] start_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // co-processor models: lat = cycles from start to valid (-1 = never)
    int          lat[NUM_CP];
    logic [31:0] val[NUM_CP];
    int          cnt_u[NUM_CP];
    logic        fire_prev[NUM_CP];
    logic [NUM_CP-1:0] noise;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void exp_start(input int c, input logic [3:0] m);
        start_q.push_back({32'(c), m});
    endfunction

    function automatic void exp_done(input int c, input logic e, input logic [31:0] r);
        logic [30:0] cc;
        cc = 31'(c);
        exp_q.push_back({cc, e, r});
    endfunction

    task automatic monitor();
        logic [63:0] e;
        logic [35:0] s;
        if (done_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e[63:33]));
                check("done_res", 64'(res_o), 64'(e[31:0]));
                check("done_err", 64'(err_o), 64'(e[32]));
            end
        end
        if (err_o && !done_o) check("err_without_done", 64'(err_o), 64'd0);
        if (cp_start_o != '0) begin
            if (start_q.size() == 0) begin
                check("spurious_start", 64'(cp_start_o), 64'd0);
            end else begin
                s = start_q.pop_front();
                check("start_cycle", 64'(cyc), 64'(s[35:4]));
                check("start_mask", 64'(cp_start_o), 64'(s[3:0]));
            end
        end
    endtask

    // unit models react to the start seen this cycle; result follows valid by one cycle
    task automatic model();
        logic v;
        for (int k = 0; k < NUM_CP; k++) begin
            cp_res_i[k*XLEN +: XLEN] = fire_prev[k] ? val[k] : $urandom;
            if (cp_start_o[k]) cnt_u[k] = lat[k];
            v = (cnt_u[k] == 0);
            if (cnt_u[k] >= 0) cnt_u[k]--;
            fire_prev[k]  = v;
            cp_valid_i[k] = v | noise[k];
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        monitor();
        model();
    endtask

    task automatic do_req(input logic [2:0] s, input logic t);
        req_i  = 1'b1;
        sel_i  = s;
        trap_i = t;
        step();
        req_i  = 1'b0;
        trap_i = 1'b0;
        sel_i  = 3'd0;
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || start_q.size() != 0) && n < limit) begin
            step();
            n++;
        end
        check(tag, 64'(exp_q.size() + start_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rstn_i = 1'b0; req_i = 1'b0; sel_i = 3'd0; trap_i = 1'b0;
        cp_valid_i = '0; cp_res_i = '0; noise = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            lat[k] = -1; val[k] = 32'h0; cnt_u[k] = -1; fire_prev[k] = 1'b0;
        end

        // reset state
        repeat (3) step();
        check("rst_start", 64'(cp_start_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_res", 64'(res_o), 64'd0);
        rstn_i = 1'b1;
        while (cyc < 10) step();

        // barrel-style unit 0: valid together with start
        lat[0] = 0; val[0] = 32'hF000_0000;
        exp_start(cyc + 1, 4'b0001);
        exp_done(cyc + 3, 1'b0, 32'hF000_0000);
        do_req(3'd0, 1'b0);
        check("t1_busy", 64'(busy_o), 64'd1);
        drain("t1_drain", 20);

        // serial-style unit 1 with valid noise on unselected units
        lat[1] = 5; val[1] = 32'h0000_0123; noise = 4'b1101;
        exp_start(cyc + 1, 4'b0010);
        exp_done(cyc + 8, 1'b0, 32'h0000_0123);
        do_req(3'd1, 1'b0);
        drain("t2_drain", 30);
        noise = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t2_res_hold", 64'(res_o), 64'h123);
        end

        // timeout on silent unit 2
        exp_start(cyc + 1, 4'b0100);
        exp_done(cyc + TMO + 2, 1'b1, 32'h0);
        do_req(3'd2, 1'b0);
        drain("t3_drain", 100);
        check("t3_busy_after", 64'(busy_o), 64'd0);

        // illegal index, then unit 3
        exp_done(cyc + 1, 1'b1, 32'h0);
        do_req(3'd5, 1'b0);
        drain("t4a_drain", 5);
        lat[3] = 2; val[3] = 32'hCAFE_0003;
        exp_start(cyc + 1, 4'b1000);
        exp_done(cyc + 5, 1'b0, 32'hCAFE_0003);
        do_req(3'd3, 1'b0);
        drain("t4b_drain", 20);

        // trap in WAIT two cycles after start
        lat[1] = 5; val[1] = 32'h0000_0555;
        exp_start(cyc + 1, 4'b0010);
        do_req(3'd1, 1'b0);
        step();
        step();
        check("t5_busy_wait", 64'(busy_o), 64'd1);
        trap_i = 1'b1;
        step();
        trap_i = 1'b0;
        check("t5_busy_trap", 64'(busy_o), 64'd0);
        repeat (10) step();
        check("t5_res_kept", 64'(res_o), 64'hCAFE_0003);
        check("t5_start_q", 64'(start_q.size()), 64'd0);

        // request while busy is dropped
        lat[0] = 3; val[0] = 32'hA5A5_0000;
        exp_start(cyc + 1, 4'b0001);
        exp_done(cyc + 6, 1'b0, 32'hA5A5_0000);
        do_req(3'd0, 1'b0);
        step();
        do_req(3'd1, 1'b0);
        drain("t6_drain", 20);

        // back-to-back: new request accepted in the done cycle
        lat[0] = 0; val[0] = 32'h1111_0000;
        lat[1] = 1; val[1] = 32'h2222_0001;
        c = cyc;
        exp_start(c + 1, 4'b0001);
        exp_done(c + 3, 1'b0, 32'h1111_0000);
        do_req(3'd0, 1'b0);
        step();
        step();
        check("t7_done_at_req", 64'(done_o), 64'd1);
        exp_start(c + 4, 4'b0010);
        exp_done(c + 7, 1'b0, 32'h2222_0001);
        do_req(3'd1, 1'b0);
        drain("t7_drain", 20);

        // trap with request in IDLE: request dropped
        do_req(3'd0, 1'b1);
        repeat (5) step();
        check("t8_busy", 64'(busy_o), 64'd0);
        check("t8_res", 64'(res_o), 64'h2222_0001);

        // trap in START even though the unit is valid
        exp_start(cyc + 1, 4'b0001);
        do_req(3'd0, 1'b0);
        trap_i = 1'b1;
        step();
        trap_i = 1'b0;
        check("t9_busy", 64'(busy_o), 64'd0);
        check("t9_start_clr", 64'(cp_start_o), 64'd0);
        repeat (5) step();
        check("t9_res", 64'(res_o), 64'h2222_0001);

        // asynchronous reset mid-operation
        exp_start(cyc + 1, 4'b0100);
        do_req(3'd2, 1'b0);
        step();
        #3;
        rstn_i = 1'b0;
        #1;
        check("t10_busy", 64'(busy_o), 64'd0);
        check("t10_res", 64'(res_o), 64'd0);
        check("t10_start", 64'(cp_start_o), 64'd0);
        check("t10_done_err", 64'({done_o, err_o}), 64'd0);
        step();
        rstn_i = 1'b1;
        repeat (3) step();
        check("t10_busy_after", 64'(busy_o), 64'd0);

        // final report
        check("final_done_q", 64'(exp_q.size()), 64'd0);
        check("final_start_q", 64'(start_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
